mem_port_arbiter: RTL and testbench

Parametrised N-port memory arbiter and bridge that lets several core-side requestors share a single Controller memory port with variable-latency response. Each requestor (instruction fetch, data load/store, debug) presents a level request. The block grants one request at a time under fixed-priority or round-robin policy. It drives the Controller strobes, waits for the memory response or a timeout, and returns data plus a one-cycle acknowledge. It also generates the per-port and aggregate hold flags that stall the core pipeline, a signal that was previously left unconnected.

---
 rtl/processorci_bus_pkg.sv | 18 +
 rtl/rr_grant.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/processorci_bus_pkg.sv
// Shared types and helpers for the core-side memory bus arbiter.
// Holds the arbiter FSM encoding, the error read-data value and packed-port slicing.
package processorci_bus_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  // Read data returned on writes and on timed-out transactions.
  localparam logic [63:0] ERR_RDATA = 64'h0;

  // LSB position of port idx inside a packed per-port bus of the given width.
  function automatic int unsigned port_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational grant selector: fixed priority (lowest index) or round-robin
// searching upward from the port after last_grant, with wrap.
module rr_grant #(
  parameter int NUM_PORTS = 2,
  parameter int RR_MODE   = 1,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 valid
);

  always_comb begin
    int cand;
    cand      = 0;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    if (RR_MODE == 0) begin
      // Scan downward so the lowest requesting index is the last one written.
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req[i]) begin
          grant_idx = IDX_W'(i);
          valid     = 1'b1;
        end
      end
    end else begin
      // Largest offset first, so the nearest port after last_grant wins.
      for (int off = NUM_PORTS; off >= 1; off--) begin
        cand = int'(last_grant) + off;
        if (cand >= NUM_PORTS) begin
          cand = cand - NUM_PORTS;
        end
        if (req[cand]) begin
          grant_idx = IDX_W'(cand);
          valid     = 1'b1;
        end
      end
    end
    if (valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port arbiter/bridge onto a single variable-latency Controller memory port,
// with per-port hold flags for stalling the core pipeline.
module mem_port_arbiter
  import processorci_bus_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RR_MODE        = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             req_i,
  input  logic [NUM_PORTS-1:0]             we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata_i,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic [NUM_PORTS-1:0]             ack_o,
  output logic                             err_o,
  output logic [NUM_PORTS-1:0]             hold_o,
  output logic                             hold_any_o,
  output logic                             mem_read_o,
  output logic                             mem_write_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
  input  logic                             mem_response_i
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t               state_reg, state_next;
  logic [NUM_PORTS-1:0]     grant_reg, grant_next;
  logic [IDX_W-1:0]         grant_idx_reg, grant_idx_next;
  logic [IDX_W-1:0]         last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]         count_reg, count_next;
  logic [NUM_PORTS-1:0]     ack_reg, ack_next;
  logic                     err_reg, err_next;
  logic [DATA_WIDTH-1:0]    rdata_reg, rdata_next;
  logic                     mem_read_reg, mem_read_next;
  logic                     mem_write_reg, mem_write_next;
  logic [ADDR_WIDTH-1:0]    mem_addr_reg, mem_addr_next;
  logic [DATA_WIDTH-1:0]    mem_wdata_reg, mem_wdata_next;

  logic [ADDR_WIDTH-1:0]    addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]    wdata_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0]     req_masked;
  logic [NUM_PORTS-1:0]     sel_grant;
  logic [IDX_W-1:0]         sel_idx;
  logic                     sel_valid;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign addr_arr[gi]  = addr_i[port_lsb(gi, ADDR_WIDTH) +: ADDR_WIDTH];
    assign wdata_arr[gi] = wdata_i[port_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];
  end

  // A port being acked this cycle still shows req high; keep it out of arbitration.
  assign req_masked = req_i & ~ack_reg;

  rr_grant #(
    .NUM_PORTS (NUM_PORTS),
    .RR_MODE   (RR_MODE),
    .IDX_W     (IDX_W)
  ) u_rr_grant (
    .req        (req_masked),
    .last_grant (last_grant_reg),
    .grant      (sel_grant),
    .grant_idx  (sel_idx),
    .valid      (sel_valid)
  );

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    grant_idx_next  = grant_idx_reg;
    last_grant_next = last_grant_reg;
    count_next      = count_reg;
    ack_next        = '0;
    err_next        = 1'b0;
    rdata_next      = rdata_reg;
    mem_read_next   = mem_read_reg;
    mem_write_next  = mem_write_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          grant_next     = sel_grant;
          grant_idx_next = sel_idx;
          mem_addr_next  = addr_arr[sel_idx];
          mem_wdata_next = wdata_arr[sel_idx];
          mem_read_next  = ~we_i[sel_idx];
          mem_write_next = we_i[sel_idx];
          count_next     = '0;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        count_next = count_reg + 1'b1;
        // A response arriving on the timeout cycle still completes normally.
        if (mem_response_i || (count_reg == TIMEOUT_LAST)) begin
          ack_next        = grant_reg;
          err_next        = ~mem_response_i;
          rdata_next      = (mem_response_i && !mem_write_reg) ? mem_rdata_i
                                                               : DATA_WIDTH'(ERR_RDATA);
          mem_read_next   = 1'b0;
          mem_write_next  = 1'b0;
          last_grant_next = grant_idx_reg;
          state_next      = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      grant_idx_reg  <= '0;
      last_grant_reg <= IDX_W'(NUM_PORTS - 1);
      count_reg      <= '0;
      ack_reg        <= '0;
      err_reg        <= 1'b0;
      rdata_reg      <= '0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      grant_idx_reg  <= grant_idx_next;
      last_grant_reg <= last_grant_next;
      count_reg      <= count_next;
      ack_reg        <= ack_next;
      err_reg        <= err_next;
      rdata_reg      <= rdata_next;
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
    end
  end

  assign ack_o       = ack_reg;
  assign err_o       = err_reg;
  assign rdata_o     = rdata_reg;
  assign mem_read_o  = mem_read_reg;
  assign mem_write_o = mem_write_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign hold_o      = req_i & ~ack_reg;
  assign hold_any_o  = |hold_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a 3-port round-robin arbiter (short timeout) and a 2-port
// fixed-priority arbiter, each driven by a small delay-programmable memory responder.
module tb_mem_port_arbiter;

  localparam logic [31:0] RD_XOR = 32'h5A5A_0000;

  logic clk;
  logic reset_n;

  // Instance A: 3 ports, round-robin, TIMEOUT_CYCLES = 8
  logic [2:0]  req_a, we_a, ack_a, hold_a;
  logic [95:0] addr_a, wdata_a;
  logic [31:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        err_a, hold_any_a, mem_read_a, mem_write_a, mem_response_a;

  // Instance B: 2 ports, fixed priority, default timeout
  logic [1:0]  req_b, we_b, ack_b, hold_b;
  logic [63:0] addr_b, wdata_b;
  logic [31:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic        err_b, hold_any_b, mem_read_b, mem_write_b, mem_response_b;

  int          resp_delay_a = 0, rcnt_a = 0, resp_delay_b = 0, rcnt_b = 0;
  logic        rd_from_addr_a = 1'b0, resp_force_a = 1'b0;
  logic [31:0] rd_const_a = '0, rd_const_b = '0;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter #(
    .NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1), .TIMEOUT_CYCLES(8)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
    .wdata_i(wdata_a), .rdata_o(rdata_a), .ack_o(ack_a), .err_o(err_a),
    .hold_o(hold_a), .hold_any_o(hold_any_a), .mem_read_o(mem_read_a),
    .mem_write_o(mem_write_a), .mem_addr_o(mem_addr_a), .mem_wdata_o(mem_wdata_a),
    .mem_rdata_i(mem_rdata_a), .mem_response_i(mem_response_a)
  );

  mem_port_arbiter #(
    .NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .rdata_o(rdata_b), .ack_o(ack_b), .err_o(err_b),
    .hold_o(hold_b), .hold_any_o(hold_any_b), .mem_read_o(mem_read_b),
    .mem_write_o(mem_write_b), .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b),
    .mem_rdata_i(mem_rdata_b), .mem_response_i(mem_response_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: pulses response on the delay-th cycle a strobe is high (0 = never).
  initial begin
    mem_response_a = 1'b0;
    mem_response_b = 1'b0;
    mem_rdata_a    = '0;
    mem_rdata_b    = '0;
    forever begin
      @(negedge clk);
      if (mem_read_a || mem_write_a) rcnt_a++; else rcnt_a = 0;
      if (mem_read_b || mem_write_b) rcnt_b++; else rcnt_b = 0;
      mem_response_a = resp_force_a || ((resp_delay_a != 0) && (rcnt_a == resp_delay_a));
      mem_response_b = (resp_delay_b != 0) && (rcnt_b == resp_delay_b);
      mem_rdata_a    = rd_from_addr_a ? (mem_addr_a ^ RD_XOR) : rd_const_a;
      mem_rdata_b    = rd_const_b;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic txn_a(input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdat, input int delay,
                       input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
    int n, n_strobe;
    logic seen, kind;
    logic [1:0] hold_seen;
    logic [31:0] seen_addr, seen_wdata;
    resp_delay_a = delay;
    rd_const_a   = rdat;
    addr_a[port*32 +: 32]  = addr;
    wdata_a[port*32 +: 32] = wdata;
    we_a[port]  = we;
    req_a[port] = 1'b1;
    n = 0; n_strobe = 0; seen = 1'b0; kind = 1'b0;
    hold_seen = '0; seen_addr = '0; seen_wdata = '0;
    while (n < 40) begin
      @(posedge clk); #1; n++;
      if (mem_read_a || mem_write_a) begin
        n_strobe++;
        if (!seen) begin
          seen       = 1'b1;
          kind       = mem_write_a;
          seen_addr  = mem_addr_a;
          seen_wdata = mem_wdata_a;
          hold_seen  = {hold_any_a, hold_a[port]};
        end
      end
      if (ack_a != 0) break;
    end
    $display("txn A port %0d we %0d lat %0d ack %b err %b rdata %h", port, we, n, ack_a, err_a, rdata_a);
    check("lat", n, exp_lat);
    check("strobe_cycles", n_strobe, exp_lat - 1);
    check("strobe_kind", kind, we);
    check("mem_addr", seen_addr, addr);
    if (we) check("mem_wdata", seen_wdata, wdata);
    check("hold_wait", hold_seen, 2'b11);
    check("ack", ack_a, 3'(1) << port);
    check("err", err_a, exp_err);
    check("rdata", rdata_a, exp_rdata);
    check("hold_ack", {hold_any_a, hold_a}, 4'b0);
    req_a[port] = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse", {err_a, ack_a}, 4'b0);
    check("idle_strobe", {mem_read_a, mem_write_a}, 2'b0);
  endtask

  task automatic wait_ack_b(output logic [1:0] ack, output int lat, output logic hold1_ok);
    ack = '0; lat = 0; hold1_ok = 1'b1;
    while (lat < 40) begin
      @(posedge clk); #1; lat++;
      hold1_ok = hold1_ok & hold_b[1];
      if (ack_b != 0) begin
        ack = ack_b;
        break;
      end
    end
    $display("txn B lat %0d ack %b rdata %h", lat, ack, rdata_b);
  endtask

  initial begin
    logic [2:0] ack_or;
    logic [1:0] ack;
    logic hold1_ok;
    int n, n_acks, exp_idx, lat;

    reset_n = 1'b0;
    req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack_err", {err_a, ack_a}, 4'b0);
    check("rst_strobes", {mem_read_a, mem_write_a}, 2'b0);
    check("rst_data", {rdata_a, mem_addr_a, mem_wdata_a}, 96'b0);
    check("rst_b", {err_b, ack_b, mem_read_b, mem_write_b}, 5'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Response pulse with no transaction open must be ignored.
    rd_const_a   = 32'hFFFF_FFFF;
    resp_force_a = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resp_force_a = 1'b0;
    check("idle_resp_ack", {err_a, ack_a}, 4'b0);
    check("idle_resp_rdata", rdata_a, 32'h0);

    // Single read, response on third strobe cycle.
    txn_a(0, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 3, 4, 1'b0, 32'hCAFE_F00D);
    // Timeout: strobe held 8 cycles, ack+err on the 9th.
    txn_a(0, 1'b0, 32'h0000_0300, 32'h0, 32'h1111_2222, 0, 9, 1'b1, 32'h0);
    // Write: rdata forced to zero even though memory drives data.
    txn_a(1, 1'b1, 32'h0000_0200, 32'h1234_5678, 32'hDEAD_BEEF, 2, 3, 1'b0, 32'h0);

    // Reset during WAIT abandons the transaction.
    resp_delay_a = 0;
    addr_a[64 +: 32] = 32'h0000_0400;
    we_a[2]  = 1'b0;
    req_a[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_strobe", mem_read_a, 1'b1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_strobes", {mem_read_a, mem_write_a}, 2'b0);
    check("rst_mid_ack", ack_a, 3'b0);
    check("rst_mid_addr", mem_addr_a, 32'h0);
    reset_n  = 1'b1;
    req_a[2] = 1'b0;
    ack_or = '0;
    repeat (3) begin
      @(posedge clk); #1;
      ack_or = ack_or | ack_a;
    end
    check("rst_no_ack", ack_or, 3'b0);

    // Round-robin contention, all ports requesting, immediate response.
    rd_from_addr_a = 1'b1;
    resp_delay_a   = 1;
    for (int i = 0; i < 3; i++) addr_a[i*32 +: 32] = 32'h1000 + i * 16;
    we_a  = '0;
    req_a = 3'b111;
    n = 0; n_acks = 0;
    while (n_acks < 6 && n < 100) begin
      @(posedge clk); #1; n++;
      if (ack_a != 0) begin
        exp_idx = n_acks % 3;
        $display("txn A rr ack %b rdata %h", ack_a, rdata_a);
        check("rr_onehot", $onehot(ack_a), 1'b1);
        check("rr_order", ack_a, 3'(1) << exp_idx);
        check("rr_rdata", rdata_a, (32'h1000 + exp_idx * 16) ^ RD_XOR);
        check("rr_hold", hold_a, 3'b111 & ~(3'(1) << exp_idx));
        check("rr_err", err_a, 1'b0);
        n_acks++;
      end
    end
    check("rr_acks", n_acks, 6);
    req_a = '0;
    rd_from_addr_a = 1'b0;

    // Fixed priority on instance B.
    resp_delay_b = 1;
    rd_const_b   = 32'h0B0B_0B0B;
    addr_b       = {32'h0000_0B10, 32'h0000_0B00};
    @(posedge clk); #1;
    req_b = 2'b11;
    wait_ack_b(ack, lat, hold1_ok);
    check("fp_first_ack", ack, 2'b01);
    check("fp_first_lat", lat, 2);
    check("fp_first_hold1", hold1_ok, 1'b1);
    check("fp_rdata", rdata_b, 32'h0B0B_0B0B);
    req_b[0] = 1'b0;
    wait_ack_b(ack, lat, hold1_ok);
    check("fp_second_ack", ack, 2'b10);
    req_b = '0;
    @(posedge clk); #1;
    req_b = 2'b01;
    wait_ack_b(ack, lat, hold1_ok);
    check("fp_solo_ack", ack, 2'b01);
    req_b = '0;
    @(posedge clk); #1;
    req_b = 2'b11;
    wait_ack_b(ack, lat, hold1_ok);
    check("fp_again_ack", ack, 2'b01);
    check("fp_again_hold1", hold1_ok, 1'b1);
    req_b = '0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
